uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel UART receiver; the receive end of the link driven by the team's UART transmitter.
//  Samples async i_rx line, validates start/parity/stop, pushes good bytes into downstream RX FIFO.
//  Sits between board RX pin and the RX FIFO feeding the CORDIC command decoder.
// PARAMETERS
//  CLK_FREQ_MHZ   100_000_000  system clock freq in Hz (name kept for TX symmetry)
//  BAUD_RATE        3_000_000  line baud rate; BAUDPER_CNT_MAX = int'(CLK_FREQ_MHZ/BAUD_RATE) (default 33)
//  NUM_DATA_BITS            8  data bits per frame, 5-9, LSB first
//  PARITY_ON                1  0: no parity bit; 1: parity bit after data
//  PARITY_EO                1  0: even (bit = ^data); 1: odd (bit = ~^data)
//  NUM_STOP_BITS            1  stop bits checked, 1-2
// PORTS
//  i_clk           in   1              system clock, single clock domain
//  i_rst           in   1              synchronous reset, active-high
//  i_rx            in   1              async serial line, idle high
//  i_fifo_full     in   1              RX FIFO full
//  o_fifo_wr_en    out  1              1-cycle write strobe to RX FIFO
//  o_fifo_wr_data  out  NUM_DATA_BITS  received byte, valid with o_fifo_wr_en
//  o_parity_err    out  1              1-cycle pulse: parity mismatch, byte dropped
//  o_frame_err     out  1              1-cycle pulse: stop bit sampled low, byte dropped
//  o_overrun       out  1              1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset (i_rst=1 at posedge): all outputs 0, sync flops 1, counters 0, state RX_IDLE; aborts any frame.
//  i_rx through 2-flop synchroniser (reset to 1) -> rx_s; all decisions use rx_s (2-cycle input latency).
//  Baud counter runs 0..BAUDPER_CNT_MAX-1; mid-bit sample point at count HALF = BAUDPER_CNT_MAX/2.
//  FSM: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP.
//   RX_IDLE: rx_s falling (1->0) -> RX_START, counter cleared.
//   RX_START: at HALF, rx_s=1 -> false start, RX_IDLE, no output; rx_s=0 -> counter cleared, RX_DATA.
//   RX_DATA: every BAUDPER_CNT_MAX-1 count sample rx_s into shift reg MSB, shift right; after
//    NUM_DATA_BITS samples -> RX_PARITY if PARITY_ON else RX_STOP.
//   RX_PARITY: one full period later sample rx_s; mismatch latches par_bad.
//   RX_STOP: sample each stop bit one period apart; any low sample latches stop_bad.
//    After last stop sample -> RX_IDLE same edge (no wait to bit end: resyncs on next start edge).
//  Completion cycle (cycle after last stop sample), exactly one of:
//   stop_bad -> o_frame_err=1 (priority over parity); else par_bad -> o_parity_err=1;
//   else i_fifo_full -> o_overrun=1; else o_fifo_wr_en=1, o_fifo_wr_data=byte.
//  o_fifo_wr_data holds last byte until next write; strobes/pulses are never >1 cycle.
//  Frame error does not re-arm until rx_s seen high (line break held low produces one frame_err only).
//  Back-to-back frames with zero idle between stop and next start are received without loss.
// CONFIGURATION
//  `define UART_RX_MAJORITY_VOTE_EN: each bit value = majority of rx_s at HALF-1, HALF, HALF+1;
//   start validation also uses the vote. Latency per sample +1 cycle; completion shifts +1 cycle.
//  Undefined: single rx_s sample at HALF. Port list and error semantics identical either way.
// TESTING (defaults: 33 clk/bit, 8 data, odd parity, 1 stop; loop uart_tx.o_tx -> i_rx)
//  TX sends 0xA5 -> exactly one o_fifo_wr_en, o_fifo_wr_data=0xA5, no error pulses.
//  Bursts 0x00,0xFF,0x55 back-to-back -> three writes in order, no errors, no gaps lost.
//  Driven frame 0x3C with parity bit inverted -> o_parity_err one pulse, no wr_en.
//  Frame 0x81 with stop bit 0; then line low 20 bit-times -> single o_frame_err, no wr_en.
//  i_rx low for 10 cycles then high (glitch) -> back to RX_IDLE, no outputs; next 0x42 received.
//  i_fifo_full=1 during 0x99 -> o_overrun pulse, no wr_en; i_rst mid-frame -> idle, frame dropped.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop sync, start/parity/stop validation and RX FIFO write strobe.
// Optional `define UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote around each bit centre.
module uart_rx #(
    parameter int CLK_FREQ_MHZ  = 100_000_000,
    parameter int BAUD_RATE     = 3_000_000,
    parameter int NUM_DATA_BITS = 8,
    parameter int PARITY_ON     = 1,
    parameter int PARITY_EO     = 1,
    parameter int NUM_STOP_BITS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rx,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_wr_en,
    output logic [NUM_DATA_BITS-1:0] o_fifo_wr_data,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
    output logic                     o_overrun
);
    localparam int BAUDPER_CNT_MAX = int'(CLK_FREQ_MHZ / BAUD_RATE);
    localparam int HALF = BAUDPER_CNT_MAX / 2;
    localparam int CW = $clog2(BAUDPER_CNT_MAX);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int START_PT = HALF + 1;
`else
    localparam int START_PT = HALF;
`endif

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} state_t;

    state_t                   r_state, w_state_nx;
    logic                     r_rx_meta, r_rx_s, r_rx_prev;
    logic [CW-1:0]            r_cnt;
    logic [3:0]               r_bit;
    logic [NUM_DATA_BITS-1:0] r_shift;
    logic                     r_par_bad, r_stop_bad;
    logic                     w_rx, w_start_pt, w_bit_pt, w_done, w_fe, w_par_exp;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_rx_h2;
    always_ff @(posedge i_clk) r_rx_h2 <= i_rst ? 1'b1 : r_rx_prev;
    // Vote over three consecutive synchronised samples, centred one cycle back.
    assign w_rx = (r_rx_h2 & r_rx_prev) | (r_rx_h2 & r_rx_s) | (r_rx_prev & r_rx_s);
`else
    assign w_rx = r_rx_s;
`endif

    assign w_start_pt = r_cnt == CW'(START_PT);
    assign w_bit_pt   = r_cnt == CW'(BAUDPER_CNT_MAX - 1);
    assign w_done     = r_state == RX_STOP && w_bit_pt && r_bit == 4'(NUM_STOP_BITS - 1);
    assign w_fe       = r_stop_bad | ~w_rx;
    assign w_par_exp  = (PARITY_EO != 0) ? ~^r_shift : ^r_shift;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RX_IDLE;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RX_IDLE:   w_state_nx = (r_rx_prev & ~r_rx_s) ? RX_START : RX_IDLE;
            RX_START:  w_state_nx = !w_start_pt ? RX_START : (w_rx ? RX_IDLE : RX_DATA);
            RX_DATA:   if (w_bit_pt && r_bit == 4'(NUM_DATA_BITS - 1))
                           w_state_nx = (PARITY_ON != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY: w_state_nx = w_bit_pt ? RX_STOP : RX_PARITY;
            RX_STOP:   w_state_nx = w_done ? RX_IDLE : RX_STOP;
            default:   w_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt          <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_par_bad      <= 1'b0;
            r_stop_bad     <= 1'b0;
            o_fifo_wr_en   <= 1'b0;
            o_fifo_wr_data <= '0;
            o_parity_err   <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            r_cnt <= (r_state == RX_IDLE || (r_state == RX_START && w_start_pt) || w_bit_pt) ? '0 : r_cnt + 1'b1;
            r_bit <= (w_state_nx != r_state) ? '0 :
                     (w_bit_pt && (r_state == RX_DATA || r_state == RX_STOP)) ? r_bit + 1'b1 : r_bit;
            if (r_state == RX_DATA && w_bit_pt)
                r_shift <= {w_rx, r_shift[NUM_DATA_BITS-1:1]};
            r_par_bad  <= (r_state == RX_IDLE) ? 1'b0 :
                          r_par_bad | (r_state == RX_PARITY && w_bit_pt && w_rx != w_par_exp);
            r_stop_bad <= (r_state == RX_IDLE) ? 1'b0 : r_stop_bad | (r_state == RX_STOP && w_bit_pt && !w_rx);
            o_frame_err  <= w_done & w_fe;
            o_parity_err <= w_done & ~w_fe & r_par_bad;
            o_overrun    <= w_done & ~w_fe & ~r_par_bad & i_fifo_full;
            o_fifo_wr_en <= w_done & ~w_fe & ~r_par_bad & ~i_fifo_full;
            if (w_done && !w_fe && !r_par_bad && !i_fifo_full)
                o_fifo_wr_data <= r_shift;
        end
    end
endmodule
